// File: rtl/arb_req_ctrl.sv
// Per-channel job queue + request/transfer sequencer in front of an external arbiter.
// Each channel queues job lengths, requests the bus, counts granted beats and releases for one cycle.
module arb_req_ctrl #(
   parameter int NUM_REQ    = 3,
   parameter int LEN_W      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       job_push,
   input  logic [NUM_REQ*LEN_W-1:0] job_len,
   output logic [NUM_REQ-1:0]       job_full,
   output logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       beat,
   output logic [NUM_REQ-1:0]       busy,
   output logic [NUM_REQ-1:0]       done,
   output logic                     grant_err
);

   // state  | meaning
   // S_IDLE | no request; waits for a queued job
   // S_REQ  | request raised, job length latched, waiting for first beat
   // S_XFER | transfer in progress, counts granted beats (pauses on grant loss)
   // S_REL  | request dropped for one cycle so the arbiter can rotate
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = LEN_W + 1;

   logic               multi_hot;
   logic               stray;
   logic [NUM_REQ-1:0] beat_ok;

   assign multi_hot = |(grant & (grant - NUM_REQ'(1)));
   assign stray     = |(grant & ~req);
   assign beat      = grant & req;
   // a multi-hot grant is ambiguous, so nobody counts a beat that cycle
   assign beat_ok   = beat & {NUM_REQ{~multi_hot}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) grant_err <= 1'b0;
      else        grant_err <= multi_hot | stray;
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
      state_t            state;
      logic [LEN_W-1:0]  mem [FIFO_DEPTH];
      logic [PW-1:0]     wr_ptr;
      logic [PW-1:0]     rd_ptr;
      logic [CW-1:0]     count;
      logic [LEN_W-1:0]  len;
      logic [BW-1:0]     cnt;
      logic              req_r;
      logic              busy_r;
      logic              done_r;
      logic              last_beat;
      logic              pop;
      logic              push_ok;
      logic              full;

      // cnt is 0 in S_REQ, so one compare covers both the first and later beats
      assign last_beat = beat_ok[i] && (cnt == {1'b0, len});
      assign pop       = (state == S_REQ || state == S_XFER) && last_beat;
      assign full      = (count == CW'(FIFO_DEPTH));
      assign push_ok   = job_push[i] && (!full || pop);

      assign job_full[i] = full;
      assign req[i]      = req_r;
      assign busy[i]     = busy_r;
      assign done[i]     = done_r;

      always_ff @(posedge clk) begin
         if (push_ok) mem[wr_ptr] <= job_len[i*LEN_W +: LEN_W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (!push_ok && pop) count <= count - CW'(1);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= S_IDLE;
            len    <= '0;
            cnt    <= '0;
            req_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
         end else begin
            done_r <= 1'b0;
            case (state)
               S_IDLE: begin
                  if (count != '0) begin
                     state <= S_REQ;
                     req_r <= 1'b1;
                     len   <= mem[rd_ptr];
                     cnt   <= '0;
                  end
               end
               S_REQ: begin
                  if (beat_ok[i]) begin
                     cnt <= BW'(1);
                     if (last_beat) begin
                        state  <= S_REL;
                        req_r  <= 1'b0;
                        done_r <= 1'b1;
                     end else begin
                        state  <= S_XFER;
                        busy_r <= 1'b1;
                     end
                  end
               end
               S_XFER: begin
                  if (beat_ok[i]) begin
                     cnt <= cnt + BW'(1);
                     if (last_beat) begin
                        state  <= S_REL;
                        req_r  <= 1'b0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Directed bench for arb_req_ctrl: per-cycle expectation tables plus a done-order scoreboard.
module tb_arb_req_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  job_push;
   logic [11:0] job_len;
   logic [2:0]  job_full;
   logic [2:0]  req;
   logic [2:0]  grant;
   logic [2:0]  beat;
   logic [2:0]  busy;
   logic [2:0]  done;
   logic        grant_err;

   logic [2:0]  grant_drv;
   logic [2:0]  rr_g;
   logic        use_rr;
   int          rr_last = 2;
   int          rr_idx;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          exp_q[$];

   always #5 clk = ~clk;

   arb_req_ctrl #(.NUM_REQ(3), .LEN_W(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .job_push(job_push), .job_len(job_len),
      .job_full(job_full), .req(req), .grant(grant), .beat(beat),
      .busy(busy), .done(done), .grant_err(grant_err)
   );

   // reference round-robin arbiter, grants only requesting channels
   always_comb begin
      rr_g   = '0;
      rr_idx = 0;
      for (int k = 1; k <= 3; k++) begin
         rr_idx = (rr_last + k) % 3;
         if (req[rr_idx] && rr_g == 3'b000) rr_g[rr_idx] = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (use_rr) begin
         for (int k = 0; k < 3; k++) if (rr_g[k]) rr_last <= k;
      end
   end

   assign grant = use_rr ? rr_g : grant_drv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: each done pulse must match the next queued completion
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done[i] === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_mis++;
               $error("FAIL done_unexpected: observed done on ch %0d expected none", i);
            end else begin
               chk("done_order", i, exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input int ch, input logic [3:0] len, input bit acc);
      job_push = '0;
      job_push[ch] = 1'b1;
      job_len[ch*4 +: 4] = len;
      if (acc) exp_q.push_back(ch);
      step();
      job_push = '0;
   endtask

   task automatic run_tbl(input string tag, input int ch, input int n, input logic [47:0] gv,
                          input logic [15:0] er, input logic [15:0] eb,
                          input logic [15:0] ed, input logic [15:0] ege);
      logic [2:0] g;
      for (int c = 0; c < n; c++) begin
         g = gv[3*c +: 3];
         grant_drv = g;
         #1;
         chk({tag, "_req"},  32'(req[ch]),   32'(er[c]));
         chk({tag, "_busy"}, 32'(busy[ch]),  32'(eb[c]));
         chk({tag, "_done"}, 32'(done[ch]),  32'(ed[c]));
         chk({tag, "_beat"}, 32'(beat[ch]),  32'(g[ch] & er[c]));
         chk({tag, "_gerr"}, 32'(grant_err), 32'(ege[c]));
         step();
      end
      grant_drv = '0;
   endtask

   initial begin
      int dcnt [3];
      int fall [3];
      int gerr;
      int bcnt;
      logic [2:0] prev_req;

      rst_n = 1'b0; job_push = '0; job_len = '0; grant_drv = '0; use_rr = 1'b0;
      @(negedge clk);
      chk("rst_req",  32'(req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_gerr", 32'(grant_err), 0);
      chk("rst_full", 32'(job_full), 0);
      step();
      rst_n = 1'b1;
      step();

      // single job, len=2: three beats, done, one REL cycle
      push(0, 4'd2, 1'b1);
      run_tbl("single", 0, 7, {9'b0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000},
              16'b0001110, 16'b0001100, 16'b0010000, 16'b0);
      chk("single_q", 32'(exp_q.size()), 0);

      // paused grant on ch1, len=3: done only after the 4th beat
      push(1, 4'd3, 1'b1);
      run_tbl("pause", 1, 10,
              {18'b0, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000},
              16'b0011111110, 16'b0011111100, 16'b0100000000, 16'b0);
      chk("pause_q", 32'(exp_q.size()), 0);

      // fill ch2 with lens 0..3, fifth push dropped
      for (int k = 0; k < 5; k++) begin
         push(2, 4'(k + 5 * (k / 4)), k < 4);
         chk("full_ch2", 32'(job_full[2]), 32'(k >= 3));
         chk("full_oth", 32'(job_full[1:0]), 0);
      end
      grant_drv = 3'b100;
      dcnt[2] = 0;
      bcnt = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         dcnt[2] += int'(done[2]);
         bcnt    += int'(beat[2]);
         step();
      end
      grant_drv = '0;
      chk("full_dones", 32'(dcnt[2]), 4);
      chk("full_beats", 32'(bcnt), 10);
      chk("full_clear", 32'(job_full), 0);
      chk("full_q",     32'(exp_q.size()), 0);
      step();

      // round robin against the reference arbiter, len=0 on all channels
      use_rr = 1'b1;
      job_push = 3'b111;
      job_len  = '0;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      step();
      job_push = '0;
      prev_req = req;
      gerr = 0;
      for (int k = 0; k < 3; k++) begin dcnt[k] = 0; fall[k] = 0; end
      for (int c = 0; c < 12; c++) begin
         step();
         for (int k = 0; k < 3; k++) begin
            dcnt[k] += int'(done[k]);
            if (prev_req[k] && !req[k]) fall[k]++;
         end
         gerr += int'(grant_err);
         prev_req = req;
      end
      for (int k = 0; k < 3; k++) begin
         chk("rr_done", 32'(dcnt[k]), 1);
         chk("rr_rel",  32'(fall[k]), 1);
      end
      chk("rr_gerr", 32'(gerr), 0);
      chk("rr_q",    32'(exp_q.size()), 0);
      use_rr = 1'b0;
      step();

      // illegal grant 011 with req 001: error pulse, no beat counted
      push(0, 4'd1, 1'b1);
      run_tbl("illegal", 0, 6, {30'b0, 3'b000, 3'b000, 3'b001, 3'b001, 3'b011, 3'b000},
              16'b001110, 16'b001000, 16'b010000, 16'b000100);
      chk("illegal_ch1", 32'(req[1] | busy[1]), 0);
      chk("illegal_q",   32'(exp_q.size()), 0);

      // reset in the middle of a len=7 transfer
      push(0, 4'd7, 1'b1);
      grant_drv = 3'b001;
      step(); step(); step(); step();
      chk("rst_mid_busy_pre", 32'(busy[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_req",  32'(req), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_done", 32'(done), 0);
      exp_q.delete();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("rst_after_req", 32'(req), 0);
      end
      grant_drv = '0;
      chk("rst_after_q", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/arb_req_ctrl.md
ARB_REQ_CTRL -- requirements
Module: arb_req_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requester channels; SHALL match the arbiter width.
REQ-002 Parameter LEN_W, default 4, job-length field width; a job SHALL be len+1 grant beats (1..16).
REQ-003 Parameter FIFO_DEPTH, default 4, job entries queued per channel.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 job_push  input  NUM_REQ  per-channel job submit strobe, one cycle per job.
REQ-007 job_len  input  NUM_REQ*LEN_W  per-channel job length; slice i sampled with job_push[i].
REQ-008 job_full  output  NUM_REQ  channel i FIFO holds FIFO_DEPTH jobs.
REQ-009 req  output  NUM_REQ  registered request vector to arbiter.
REQ-010 grant  input  NUM_REQ  grant vector from arbiter, one-hot or zero.
REQ-011 beat  output  NUM_REQ  combinational: beat[i] = grant[i] AND req[i]; one data beat per high cycle.
REQ-012 busy  output  NUM_REQ  registered: channel i in XFER.
REQ-013 done  output  NUM_REQ  registered one-cycle pulse: channel i completed a job.
REQ-014 grant_err  output  1  registered one-cycle pulse: illegal grant seen.

Function
REQ-015 Each channel SHALL own an independent FIFO (FIFO_DEPTH x LEN_W), a beat counter (LEN_W+1 bits) and a 4-state FSM: IDLE, REQ, XFER, REL.
REQ-016 IDLE: req[i]=0; FIFO non-empty -> REQ next cycle.
REQ-017 REQ: req[i]=1; first cycle with beat[i]=1 counts beat 1; if head len=0 -> REL with done pulse, else -> XFER.
REQ-018 XFER: req[i]=1, busy[i]=1; counter increments only on beat[i]=1 cycles; grant loss mid-job SHALL pause, not abort, with req held high.
REQ-019 XFER: beat number len+1 -> done[i] pulse next cycle, FIFO pop, -> REL.
REQ-020 REL: req[i]=0 for exactly one cycle (lets arbiter rotate), then -> IDLE; back-to-back jobs therefore re-request after IDLE, minimum 2 cycles of req low-to-high gap including REL and IDLE.
REQ-021 Push accepted when FIFO not full, or when full and a pop occurs the same cycle; otherwise push SHALL be dropped with no state change.
REQ-022 job_full SHALL reflect the registered occupancy after the current edge's push/pop.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL never exceed FIFO_DEPTH nor go negative.
REQ-024 Length SHALL be taken from FIFO head at REQ entry and held constant for the job.
REQ-025 grant_err SHALL pulse the cycle after grant has more than one bit set, or grant[i]=1 with req[i]=0; such stray grant bits SHALL NOT advance any channel.
REQ-026 Multi-hot grant: no channel SHALL count a beat that cycle.
REQ-027 Channels SHALL operate concurrently; push on channel i SHALL never affect channel j.

Reset
REQ-028 rst_n low SHALL immediately force req=0, busy=0, done=0, grant_err=0, job_full=0, all FSMs IDLE, FIFOs empty, counters 0.
REQ-029 Reset mid-job SHALL discard queued and in-flight jobs; no done pulse SHALL be emitted for them.
REQ-030 First req after rst_n release SHALL require a new job_push.

Verification
REQ-031 Single job: push ch0 len=2, grant=001 continuous -> req[0]=1, beat[0] 3 cycles, done[0] pulse, req[0]=0 one REL cycle, then idle.
REQ-032 Paused grant: push ch1 len=3, grant 010 for 2 cycles, 000 for 3 cycles, 010 again -> busy[1] stays 1, req[1] held, done[1] after 4th beat only.
REQ-033 FIFO full: 5 pushes ch2 with no grant -> job_full[2]=1 after 4th, 5th dropped; grant 100 continuously -> exactly 4 done[2] pulses.
REQ-034 Round-robin with real arbiter: jobs len=0 on all three channels, req=111 -> grants rotate, each channel one done, each req drops one cycle in REL.
REQ-035 Illegal grant: grant=011 with req=001 -> grant_err pulse next cycle, no beat counted on any channel.
REQ-036 Reset mid-XFER: ch0 len=7 after 3 beats, rst_n low -> req=000, busy=000 same instant, no done[0] after release.
